// File: rtl/pmem_types_pkg.sv
// Shared types and sizing for the cache-to-memory burst path.
// Line and beat widths, beat count and the adaptor state encoding.
package pmem_types_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts whole-line cache requests into fixed-length memory bursts.
// One line register is both the read assembly buffer and the write source.
module cacheline_adaptor #(
  parameter int LINE_W  = pmem_types_pkg::LINE_W,
  parameter int BURST_W = pmem_types_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  import pmem_types_pkg::*;

  localparam int N_BEATS = LINE_W / BURST_W;
  localparam int KW      = $clog2(N_BEATS);
  localparam int OFF     = $clog2(LINE_W / 8);

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [31:0]         r_addr;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_line_o;

  logic                w_last;
  logic [31:0]         w_addr_al;
  logic [BURST_W-1:0]  w_beat;

  assign w_last    = (r_k == KW'(N_BEATS - 1));
  assign w_addr_al = {address_i[31:OFF], {OFF{1'b0}}};
  assign w_beat    = r_line[int'(r_k) * BURST_W +: BURST_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_addr   <= '0;
      r_line   <= '0;
      r_line_o <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (write_i) begin
            r_line  <= line_i;
            r_addr  <= w_addr_al;
            r_k     <= '0;
            r_state <= WR_BURST;
          end else if (read_i) begin
            r_addr  <= w_addr_al;
            r_k     <= '0;
            r_state <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            r_line[int'(r_k) * BURST_W +: BURST_W] <= burst_i;
            r_k <= r_k + 1'b1;
            // Final beat is the top slice; publish the completed line.
            if (w_last) begin
              r_line_o <= {burst_i, r_line[LINE_W-BURST_W-1:0]};
              r_state  <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            r_k <= r_k + 1'b1;
            if (w_last) r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign read_o    = (r_state == RD_BURST);
  assign write_o   = (r_state == WR_BURST);
  assign resp_o    = (r_state == DONE);
  assign address_o = r_addr;
  assign burst_o   = write_o ? w_beat : '0;
  assign line_o    = r_line_o;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized bench for cacheline_adaptor.
// Expected lines and beats come from a queue-based model of the protocol.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_pat(output bit pat[$]);
    int ones = 0;
    pat = {};
    while (ones < 4) begin
      bit b = 1'($urandom_range(0, 1));
      pat.push_back(b);
      if (b) ones++;
    end
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input bit pat[$],
                         input bit fixed,
                         input logic [63:0] fd[4],
                         input logic [255:0] prev,
                         output logic [255:0] got);
    logic [63:0] acc[$];
    logic [63:0] d;
    logic [31:0] al = {addr[31:5], 5'b0};
    int n = 0;
    read_i = 1'b1; write_i = 1'b0; address_i = addr;
    @(negedge clk);
    read_i = 1'b0; address_i = $urandom;
    foreach (pat[i]) begin
      chk("rd_read_o", read_o, 1);
      chk("rd_write_o", write_o, 0);
      chk("rd_addr", address_o, al);
      chk("rd_resp_o", resp_o, 0);
      chk("rd_burst_o", burst_o, 0);
      chk("rd_line_hold", line_o, prev);
      d = (fixed && pat[i]) ? fd[n] : rnd64();
      resp_i = pat[i]; burst_i = d;
      read_i = 1'($urandom); write_i = 1'($urandom);
      if (pat[i]) begin
        acc.push_back(d);
        n++;
      end
      @(negedge clk);
    end
    got = {acc[3], acc[2], acc[1], acc[0]};
    chk("rd_beats", acc.size(), 4);
    chk("rd_done_resp", resp_o, 1);
    chk("rd_done_read_o", read_o, 0);
    chk("rd_done_write_o", write_o, 0);
    chk("rd_done_burst_o", burst_o, 0);
    chk("rd_line", line_o, got);
    resp_i = 1'($urandom); read_i = 1'($urandom); write_i = 1'($urandom);
    @(negedge clk);
    chk("rd_idle_resp", resp_o, 0);
    chk("rd_idle_read_o", read_o, 0);
    chk("rd_idle_write_o", write_o, 0);
    chk("rd_idle_line", line_o, got);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [255:0] wl,
                          input bit both,
                          input bit pat[$],
                          input logic [255:0] keep);
    logic [31:0] al = {addr[31:5], 5'b0};
    int n = 0;
    write_i = 1'b1; read_i = both; line_i = wl; address_i = addr;
    @(negedge clk);
    write_i = 1'b0; read_i = 1'b0; line_i = ~wl; address_i = $urandom;
    foreach (pat[i]) begin
      chk("wr_write_o", write_o, 1);
      chk("wr_read_o", read_o, 0);
      chk("wr_addr", address_o, al);
      chk("wr_resp_o", resp_o, 0);
      chk("wr_burst_o", burst_o, wl[64*n +: 64]);
      chk("wr_line_keep", line_o, keep);
      resp_i = pat[i]; burst_i = rnd64();
      read_i = 1'($urandom); write_i = 1'($urandom);
      if (pat[i]) n++;
      @(negedge clk);
    end
    chk("wr_done_resp", resp_o, 1);
    chk("wr_done_write_o", write_o, 0);
    chk("wr_done_burst_o", burst_o, 0);
    chk("wr_done_line", line_o, keep);
    resp_i = 1'($urandom); read_i = 1'($urandom); write_i = 1'($urandom);
    @(negedge clk);
    chk("wr_idle_resp", resp_o, 0);
    chk("wr_idle_write_o", write_o, 0);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
  endtask

  initial begin
    logic [63:0]  fd[4];
    logic [63:0]  none[4];
    logic [255:0] cur;
    logic [255:0] nxt;
    logic [255:0] wl;
    logic [31:0]  a;
    bit pat[$];

    rst = 1'b1; line_i = '0; address_i = '0;
    read_i = 1'b0; write_i = 1'b0; burst_i = '0; resp_i = 1'b0;
    foreach (none[i]) none[i] = '0;

    #12;
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_line_o", line_o, 0);
    @(negedge clk);
    rst = 1'b0;

    resp_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_resp_i_read_o", read_o, 0);
      chk("idle_resp_i_write_o", write_o, 0);
      chk("idle_resp_i_resp_o", resp_o, 0);
    end
    resp_i = 1'b0;

    fd[0] = {8{8'h11}}; fd[1] = {8{8'h22}};
    fd[2] = {8{8'h33}}; fd[3] = {8{8'h44}};
    pat = '{1, 1, 1, 1};
    do_read(32'h0000_1234, pat, 1'b1, fd, '0, cur);
    chk("dir_line", cur, {fd[3], fd[2], fd[1], fd[0]});

    wl = 256'h0123456789ABCDEF_1032547698BADCFE_AABBCCDDEEFF0011_7654321089ABCDEF;
    do_write(32'h0000_BEEF, wl, 1'b0, pat, cur);

    pat = '{1, 0, 0, 1, 0, 1, 1};
    do_read($urandom, pat, 1'b0, none, cur, nxt);
    cur = nxt;

    pat = '{1, 1, 0, 1, 1};
    do_write($urandom, {rnd64(), rnd64(), rnd64(), rnd64()}, 1'b1, pat, cur);

    a = $urandom;
    read_i = 1'b1; address_i = a;
    @(negedge clk);
    read_i = 1'b0;
    repeat (2) begin
      resp_i = 1'b1; burst_i = rnd64();
      @(negedge clk);
    end
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_read_o", read_o, 0);
    chk("arst_write_o", write_o, 0);
    chk("arst_resp_o", resp_o, 0);
    chk("arst_addr", address_o, 0);
    chk("arst_burst_o", burst_o, 0);
    chk("arst_line_o", line_o, 0);
    resp_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_resp", resp_o, 0);
    end
    rst = 1'b0; resp_i = 1'b0;
    pat = '{1, 1, 1, 1};
    do_read($urandom, pat, 1'b0, none, '0, cur);

    for (int it = 0; it < 6; it++) begin
      rand_pat(pat);
      if ($urandom_range(0, 1) == 1) begin
        do_read($urandom, pat, 1'b0, none, cur, nxt);
        cur = nxt;
      end else begin
        do_write($urandom, {rnd64(), rnd64(), rnd64(), rnd64()},
                 1'($urandom), pat, cur);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, the cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, the memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port line_i, input, LINE_W bits, the line write data from the cache (pmem_wdata).
REQ-006 SHALL have port line_o, output, LINE_W bits, the line read data to the cache (pmem_rdata).
REQ-007 SHALL have port address_i, input, 32 bits, the line address from the cache (pmem_address).
REQ-008 SHALL have ports read_i and write_i, input, 1 bit each, the line read and line write requests from the cache.
REQ-009 SHALL have port resp_o, output, 1 bit, the one-cycle line completion to the cache.
REQ-010 SHALL have port burst_i, input, BURST_W bits, the read beat data from memory.
REQ-011 SHALL have port burst_o, output, BURST_W bits, the write beat data to memory.
REQ-012 SHALL have port address_o, output, 32 bits, the burst address to memory.
REQ-013 SHALL have ports read_o and write_o, output, 1 bit each, the burst requests to memory.
REQ-014 SHALL have port resp_i, input, 1 bit; a high value means the current beat is accepted or valid.

Function
REQ-015 SHALL implement the states IDLE, RD_BURST, WR_BURST and DONE.
REQ-016 In IDLE, write_i=1 SHALL latch line_i and {address_i[31:5],5'b0}, clear the beat counter and go to WR_BURST; write_i has priority over read_i.
REQ-017 In IDLE, read_i=1 with write_i=0 SHALL latch the aligned address, clear the beat counter and go to RD_BURST.
REQ-018 Requests SHALL be sampled only in IDLE and ignored in every other state.
REQ-019 In RD_BURST, read_o=1 and address_o SHALL hold the latched address.
REQ-020 Each cycle of RD_BURST with resp_i=1 SHALL store burst_i into line bits [64k+63:64k] for beat k and increment k.
REQ-021 Beats need not be consecutive; a cycle with resp_i=0 SHALL hold k and the line data.
REQ-022 In WR_BURST, write_o=1, address_o SHALL hold the latched address, and burst_o SHALL equal latched line bits [64k+63:64k].
REQ-023 In WR_BURST, resp_i=1 SHALL advance k.
REQ-024 The beat with resp_i=1 at k=3 SHALL end the burst and move to DONE on the next edge; read_o and write_o SHALL be 0 in DONE.
REQ-025 In DONE, resp_o SHALL be 1 for exactly one cycle, and the state SHALL then return to IDLE unconditionally.
REQ-026 Minimum latency from request to resp_o SHALL be 6 cycles: 1 latch cycle, 4 beats, then DONE.
REQ-027 line_o SHALL hold the last assembled line from DONE until the next read completes.
REQ-028 resp_i in IDLE or DONE SHALL be ignored.
REQ-029 burst_o SHALL be 0 outside WR_BURST.
REQ-030 The beat counter SHALL be 2 bits; wrap after beat 3 SHALL coincide with leaving the burst state.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, k=0, read_o=write_o=resp_o=0, address_o=0, burst_o=0 and line_o=0, including mid-burst.
REQ-032 A burst aborted by reset SHALL never produce resp_o.

Structure
REQ-033 The state enum and the LINE_W/BURST_W/BEATS constants SHALL live in the shared package pmem_types_pkg.
REQ-034 The block SHALL be flat with no sub-module; the line register serves as both the read assembly buffer and the write source.

Verification
REQ-035 The bench SHALL cover this read: read_i with address_i=0x0000_1234, memory returning beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles; required response: address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, and resp_o high on cycle 6.
REQ-036 The bench SHALL cover this write: write_i with line_i=256'h0123...CDEF; required response: burst_o presents bits [63:0], [127:64], [191:128], [255:192] in order with write_o=1, then one resp_o pulse.
REQ-037 The bench SHALL cover gapped beats: resp_i pattern 1,0,0,1,0,1,1; required response: exactly four beats captured, no duplicate, and resp_o one cycle after the last beat.
REQ-038 The bench SHALL cover simultaneous requests: read_i=write_i=1 in IDLE; required response: write_o asserts and read_o stays 0.
REQ-039 The bench SHALL cover reset mid-operation: rst pulsed after beat 2 of a read; required response: all outputs 0 asynchronously, no resp_o, and a subsequent read completes correctly.
REQ-040 The bench SHALL cover a back-to-back sequence: a read followed immediately by a write request after resp_o; required response: the write starts from IDLE, and line_o retains the read data throughout the write.
